ysyx_25030093_wbu: RTL and testbench
====================================

YSYX_25030093_WBU -- requirements
Module: ysyx_25030093_WBU

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, named as in the register file: clk, rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 issue_valid  in  1  decoder issues an instruction that writes issue_rd.
REQ-007 issue_rd  in  ADDR_WIDTH  destination register of the issued instruction.
REQ-008 issue_ready  out  1  issue accepted; combinational.
REQ-009 exu_valid / exu_ready  in / out  1 / 1  ALU result handshake.
REQ-010 exu_rd, exu_data  in  ADDR_WIDTH, DATA_WIDTH  ALU destination and result.
REQ-011 lsu_valid / lsu_ready  in / out  1 / 1  load-result handshake.
REQ-012 lsu_rd, lsu_data  in  ADDR_WIDTH, DATA_WIDTH  load destination and data.
REQ-013 rf_wen, rf_waddr, rf_wdata  out  1, ADDR_WIDTH, DATA_WIDTH  drive the register-file write port; registered.
REQ-014 chk_rs1, chk_rs2  in  ADDR_WIDTH  source indices to check.
REQ-015 rs1_busy, rs2_busy  out  1  source has a pending write; combinational.
REQ-016 wb_count  out  32  number of completed writebacks.

Function
REQ-017 A transfer SHALL occur when valid and ready are both 1 at a rising edge (fire).
REQ-018 lsu_ready SHALL be 1 whenever the state is IDLE or WRITE; the unit never back-pressures LSU.
REQ-019 exu_ready SHALL equal !lsu_valid; LSU has fixed priority, and EXU holds its payload stable while not ready.
REQ-020 FSM states SHALL be IDLE and WRITE: any fire -> WRITE; in WRITE with no fire -> IDLE; in WRITE with a fire -> WRITE.
REQ-021 The cycle after a fire, rf_wen SHALL be 1 for exactly one cycle with the fired rd and data (latency 1).
REQ-022 rd = 0 SHALL be consumed normally, keep rf_wen = 0, and still increment wb_count.
REQ-023 The scoreboard SHALL hold one busy bit per register; bit 0 is hard-wired to 0.
REQ-024 issue_ready SHALL equal !busy[issue_rd] (WAW stall); an issue fire sets busy[issue_rd].
REQ-025 The edge on which rf_wen = 1 SHALL clear busy[rf_waddr].
REQ-026 If a set and a clear target the same index on the same edge, set SHALL win.
REQ-027 rsN_busy SHALL equal busy[chk_rsN]; it is 0 for index 0.
REQ-028 rsN_busy SHALL remain 1 during the rf_wen cycle, so a consumer reads the register-file value one cycle later.
REQ-029 wb_count SHALL increment by 1 per fire and wrap modulo 2^32.

Reset
REQ-030 On rst, the following SHALL apply asynchronously: state = IDLE, rf_wen = 0, rf_waddr = 0, rf_wdata = 0, all busy bits = 0, wb_count = 0.
REQ-031 An assertion of rst mid-operation SHALL drop any write still in the output register; rf_wen never pulses after rst.
REQ-032 In the first cycle after rst deasserts, issue_ready SHALL be 1 and both ready outputs SHALL be 1 when the matching valid is absent.

Structure
REQ-033 The shared package SHALL hold ADDR_WIDTH, DATA_WIDTH and the state enum {IDLE, WRITE}.
REQ-034 The scoreboard SHALL be the sub-module ysyx_25030093_Scoreboard, with set port, clear port and two check ports.
REQ-035 The arbiter, output register, FSM and counter SHALL reside in the top module.

Verification
REQ-036 Issue rd = 5, then exu_valid with rd = 5 and data 0x12345678 -> rf_wen = 1 next cycle with waddr 5 and data 0x12345678; rs1_busy(5) = 1 until that edge, then 0.
REQ-037 LSU (rd = 3, 0xAAAA0000) and EXU (rd = 4, 0x55) both valid -> LSU written first, exu_ready = 0 for that cycle, EXU written the next cycle; wb_count = 2.
REQ-038 Busy rd = 7 with issue_valid for rd = 7 -> issue_ready = 0 until the rd = 7 writeback edge, then 1.
REQ-039 Clear of rd = 9 and issue of rd = 9 on the same edge -> busy[9] = 1 afterwards.
REQ-040 exu_valid with rd = 0 and data 0xFFFFFFFF -> rf_wen stays 0, wb_count increments, busy unaffected.
REQ-041 rst asserted the cycle after a fire -> no rf_wen pulse, all outputs at reset values immediately.

Source files
------------

// File: rtl/ysyx_25030093_wbu_pkg.sv
// Shared widths and FSM state type for the writeback unit.
package ysyx_25030093_wbu_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic {
    StIdle  = 1'b0,
    StWrite = 1'b1
  } wbu_state_e;

endpackage

// File: rtl/ysyx_25030093_wbu_scoreboard.sv
// Register busy scoreboard: one pending-write bit per architectural register.
// Index 0 never reports busy. A set and a clear on the same index and edge leave it set.
module ysyx_25030093_Scoreboard #(
  parameter int unsigned ADDR_WIDTH = ysyx_25030093_wbu_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  // Set port: mark a destination as pending and report its current state
  input  logic                  set_en_i,
  input  logic [ADDR_WIDTH-1:0] set_idx_i,
  output logic                  set_busy_o,
  // Clear port: writeback completed
  input  logic                  clr_en_i,
  input  logic [ADDR_WIDTH-1:0] clr_idx_i,
  // Check ports
  input  logic [ADDR_WIDTH-1:0] chk_a_idx_i,
  output logic                  chk_a_busy_o,
  input  logic [ADDR_WIDTH-1:0] chk_b_idx_i,
  output logic                  chk_b_busy_o
);
  import ysyx_25030093_wbu_pkg::*;

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [NumRegs-1:0] busy_q, busy_d;

  // Next busy vector: clear first so a same-index set overrides it.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) begin
      busy_d[clr_idx_i] = 1'b0;
    end
    if (set_en_i) begin
      busy_d[set_idx_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy bit storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign set_busy_o   = busy_q[set_idx_i];
  assign chk_a_busy_o = busy_q[chk_a_idx_i];
  assign chk_b_busy_o = busy_q[chk_b_idx_i];

endmodule

// File: rtl/ysyx_25030093_wbu.sv
// Writeback unit: arbitrates LSU/EXU results onto the register-file write port,
// tracks pending destinations for hazard checks and counts completed writebacks.
module ysyx_25030093_wbu #(
  parameter int unsigned ADDR_WIDTH = ysyx_25030093_wbu_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ysyx_25030093_wbu_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  // Issue side
  input  logic                  issue_valid_i,
  input  logic [ADDR_WIDTH-1:0] issue_rd_i,
  output logic                  issue_ready_o,
  // ALU results
  input  logic                  exu_valid_i,
  output logic                  exu_ready_o,
  input  logic [ADDR_WIDTH-1:0] exu_rd_i,
  input  logic [DATA_WIDTH-1:0] exu_data_i,
  // Load results
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,
  // Register-file write port
  output logic                  rf_wen_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  // Source hazard checks
  input  logic [ADDR_WIDTH-1:0] chk_rs1_i,
  input  logic [ADDR_WIDTH-1:0] chk_rs2_i,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o,
  // Completed writeback count
  output logic [31:0]           wb_count_o
);
  import ysyx_25030093_wbu_pkg::*;

  wbu_state_e            state_q;
  logic                  rf_wen_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic [31:0]           wb_count_q;

  logic                  lsu_fire, exu_fire, fire;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  issue_busy;
  logic                  issue_fire;

  // LSU is never back-pressured in either state; EXU waits whenever LSU is presenting.
  assign lsu_ready_o = (state_q == StIdle) || (state_q == StWrite);
  assign exu_ready_o = !lsu_valid_i;

  // Fixed-priority arbiter: LSU wins over EXU.
  always_comb begin
    lsu_fire = lsu_valid_i && lsu_ready_o;
    exu_fire = exu_valid_i && exu_ready_o;
    fire     = lsu_fire || exu_fire;
    sel_rd   = '0;
    sel_data = '0;
    if (lsu_fire) begin
      sel_rd   = lsu_rd_i;
      sel_data = lsu_data_i;
    end else if (exu_fire) begin
      sel_rd   = exu_rd_i;
      sel_data = exu_data_i;
    end
  end

  // FSM, output register and writeback counter; rd 0 is consumed but never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle:  state_q <= fire ? StWrite : StIdle;
        StWrite: state_q <= fire ? StWrite : StIdle;
        default: state_q <= StIdle;
      endcase
      rf_wen_q <= fire && (sel_rd != '0);
      if (fire) begin
        rf_waddr_q <= sel_rd;
        rf_wdata_q <= sel_data;
        wb_count_q <= wb_count_q + 32'd1;
      end
    end
  end

  // WAW stall: a destination may not be reissued while its write is pending.
  assign issue_ready_o = !issue_busy;
  assign issue_fire    = issue_valid_i && issue_ready_o;

  ysyx_25030093_Scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .set_en_i     (issue_fire),
    .set_idx_i    (issue_rd_i),
    .set_busy_o   (issue_busy),
    .clr_en_i     (rf_wen_q),
    .clr_idx_i    (rf_waddr_q),
    .chk_a_idx_i  (chk_rs1_i),
    .chk_a_busy_o (rs1_busy_o),
    .chk_b_idx_i  (chk_rs2_i),
    .chk_b_busy_o (rs2_busy_o)
  );

  assign rf_wen_o   = rf_wen_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign wb_count_o = wb_count_q;

endmodule

// File: tb/tb_ysyx_25030093_wbu.sv
// Directed bench for the writeback unit with a queue of expected register-file writes.
module tb_ysyx_25030093_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd;
  logic        exu_valid, exu_ready;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  chk_rs1, chk_rs2;
  logic        rs1_busy, rs2_busy;
  logic [31:0] wb_count;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int unsigned due;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_wb = 0;

  ysyx_25030093_wbu dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .issue_ready_o (issue_ready),
    .exu_valid_i   (exu_valid),
    .exu_ready_o   (exu_ready),
    .exu_rd_i      (exu_rd),
    .exu_data_i    (exu_data),
    .lsu_valid_i   (lsu_valid),
    .lsu_ready_o   (lsu_ready),
    .lsu_rd_i      (lsu_rd),
    .lsu_data_i    (lsu_data),
    .rf_wen_o      (rf_wen),
    .rf_waddr_o    (rf_waddr),
    .rf_wdata_o    (rf_wdata),
    .chk_rs1_i     (chk_rs1),
    .chk_rs2_i     (chk_rs2),
    .rs1_busy_o    (rs1_busy),
    .rs2_busy_o    (rs2_busy),
    .wb_count_o    (wb_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input int unsigned due);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.due  = due;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every write pulse must match the oldest expected write in its due cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_wen) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wen", {31'd0, rf_wen}, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", {27'd0, rf_waddr}, {27'd0, e.addr});
          check("wr_data", rf_wdata, e.data);
          check("wr_cycle", cyc, e.due);
        end
      end else if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        check("wen_missing", {31'd0, rf_wen}, 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0; issue_rd = '0;
    exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    chk_rs1 = '0; chk_rs2 = '0;
    tick(); tick();
    check("rst_wen", {31'd0, rf_wen}, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_wb_count", wb_count, 32'd0);

    // First cycle out of reset
    rst = 1'b0;
    issue_rd = 5'd5; chk_rs1 = 5'd5;
    settle();
    check("post_rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    check("post_rst_exu_ready", {31'd0, exu_ready}, 32'd1);
    check("post_rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    check("post_rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);

    // Issue rd 5, then EXU writes it
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    settle();
    check("rd5_busy_after_issue", {31'd0, rs1_busy}, 32'd1);
    check("rd5_waw_stall", {31'd0, issue_ready}, 32'd0);
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h1234_5678;
    expect_wr(5'd5, 32'h1234_5678, cyc + 1);
    exp_wb++;
    settle();
    check("exu_ready_alone", {31'd0, exu_ready}, 32'd1);
    tick();
    exu_valid = 1'b0;
    settle();
    check("rd5_wen", {31'd0, rf_wen}, 32'd1);
    check("rd5_busy_during_wen", {31'd0, rs1_busy}, 32'd1);
    tick();
    settle();
    check("rd5_busy_after_wb", {31'd0, rs1_busy}, 32'd0);
    check("wen_single_cycle", {31'd0, rf_wen}, 32'd0);
    check("wb_count_1", wb_count, exp_wb);

    // LSU and EXU together: LSU first
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'hAAAA_0000;
    exu_valid = 1'b1; exu_rd = 5'd4; exu_data = 32'h0000_0055;
    expect_wr(5'd3, 32'hAAAA_0000, cyc + 1);
    expect_wr(5'd4, 32'h0000_0055, cyc + 2);
    exp_wb += 2;
    settle();
    check("exu_ready_blocked", {31'd0, exu_ready}, 32'd0);
    check("lsu_ready_conflict", {31'd0, lsu_ready}, 32'd1);
    tick();
    lsu_valid = 1'b0;
    settle();
    check("exu_ready_released", {31'd0, exu_ready}, 32'd1);
    tick();
    exu_valid = 1'b0;
    tick();
    settle();
    check("wb_count_3", wb_count, exp_wb);

    // WAW stall on rd 7 until its writeback edge
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    settle();
    check("rd7_stall_a", {31'd0, issue_ready}, 32'd0);
    tick();
    settle();
    check("rd7_stall_b", {31'd0, issue_ready}, 32'd0);
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h0000_7777;
    expect_wr(5'd7, 32'h0000_7777, cyc + 1);
    exp_wb++;
    tick();
    exu_valid = 1'b0;
    settle();
    check("rd7_stall_during_wen", {31'd0, issue_ready}, 32'd0);
    tick();
    settle();
    check("rd7_ready_after_wb", {31'd0, issue_ready}, 32'd1);
    issue_valid = 1'b0;

    // Clear and set of rd 9 on the same edge: set wins
    exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h0000_0099;
    expect_wr(5'd9, 32'h0000_0099, cyc + 1);
    exp_wb++;
    tick();
    exu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    settle();
    check("rd9_ready_in_wen", {31'd0, issue_ready}, 32'd1);
    tick();
    issue_valid = 1'b0;
    chk_rs2 = 5'd9;
    settle();
    check("rd9_set_wins", {31'd0, rs2_busy}, 32'd1);
    tick();
    settle();
    check("rd9_stays_busy", {31'd0, rs2_busy}, 32'd1);

    // rd 0: consumed and counted, never written
    exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'hFFFF_FFFF;
    exp_wb++;
    tick();
    exu_valid = 1'b0;
    settle();
    check("rd0_no_wen", {31'd0, rf_wen}, 32'd0);
    tick();
    settle();
    check("rd0_wb_count", wb_count, exp_wb);
    check("rd0_busy9_kept", {31'd0, rs2_busy}, 32'd1);
    chk_rs1 = 5'd0;
    issue_valid = 1'b1; issue_rd = 5'd0;
    settle();
    check("rd0_issue_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    issue_valid = 1'b0;
    settle();
    check("rd0_never_busy", {31'd0, rs1_busy}, 32'd0);

    // Reset right after a fire drops the pending write
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'h00C0_FFEE;
    tick();
    lsu_valid = 1'b0;
    rst = 1'b1;
    settle();
    check("midrst_wen", {31'd0, rf_wen}, 32'd0);
    check("midrst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("midrst_wdata", rf_wdata, 32'd0);
    check("midrst_wb_count", wb_count, 32'd0);
    check("midrst_busy9", {31'd0, rs2_busy}, 32'd0);
    tick();
    check("midrst_wen_held", {31'd0, rf_wen}, 32'd0);
    rst = 1'b0;
    issue_rd = 5'd9;
    settle();
    check("after_rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    check("after_rst_exu_ready", {31'd0, exu_ready}, 32'd1);
    check("after_rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
    tick();
    settle();
    check("after_rst_no_wen", {31'd0, rf_wen}, 32'd0);
    tick();

    check("pending_writes_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
